// File: rtl/serializer_8b10b.sv
`default_nettype none
// ============================================================================
//  Module   : serializer_8b10b
//  Purpose  : Transmit-side 8b/10b encoder and serializer. Bytes arrive over
//             a valid/ready handshake into a one-entry holding register. Each
//             byte is encoded (Widmer-Franaszek, running disparity tracked)
//             into a 10-bit shifter and sent one bit per clock, a first and
//             j last, with no gap between back-to-back symbols.
//  Ports    : i_Clk       - bit clock, one serial bit per rising edge
//             i_Rst       - synchronous active-high reset
//             i_Data[7:0] - byte to encode (HGF = [7:5], EDCBA = [4:0])
//             i_Valid     - i_Data valid
//             i_K         - encode as control character (SERIALIZER_KCHAR_EN)
//             o_Ready     - holding register empty
//             o_Data_Out  - serial bit
//             o_Tx_Active - o_Data_Out carries a symbol bit this cycle
//             o_Rd        - running disparity after the symbol being shifted
//             o_K_Err     - one-cycle pulse on an invalid K request
//                           (SERIALIZER_KCHAR_EN)
//  Options  : SERIALIZER_KCHAR_EN - adds K-character support (i_K, o_K_Err)
//  Revision : 1.0 - initial release
// ============================================================================
module serializer_8b10b (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic [7:0] i_Data,
  input  logic       i_Valid,
`ifdef SERIALIZER_KCHAR_EN
  input  logic       i_K,
  output logic       o_K_Err,
`endif
  output logic       o_Ready,
  output logic       o_Data_Out,
  output logic       o_Tx_Active,
  output logic       o_Rd
);

  // 5b/6b table, RD- column, abcdei with a in the MSB.
  function automatic logic [5:0] enc6_rdn(input logic [4:0] x);
    case (x)
      5'd0:    enc6_rdn = 6'b100111;  5'd1:  enc6_rdn = 6'b011101;
      5'd2:    enc6_rdn = 6'b101101;  5'd3:  enc6_rdn = 6'b110001;
      5'd4:    enc6_rdn = 6'b110101;  5'd5:  enc6_rdn = 6'b101001;
      5'd6:    enc6_rdn = 6'b011001;  5'd7:  enc6_rdn = 6'b111000;
      5'd8:    enc6_rdn = 6'b111001;  5'd9:  enc6_rdn = 6'b100101;
      5'd10:   enc6_rdn = 6'b010101;  5'd11: enc6_rdn = 6'b110100;
      5'd12:   enc6_rdn = 6'b001101;  5'd13: enc6_rdn = 6'b101100;
      5'd14:   enc6_rdn = 6'b011100;  5'd15: enc6_rdn = 6'b010111;
      5'd16:   enc6_rdn = 6'b011011;  5'd17: enc6_rdn = 6'b100011;
      5'd18:   enc6_rdn = 6'b010011;  5'd19: enc6_rdn = 6'b110010;
      5'd20:   enc6_rdn = 6'b001011;  5'd21: enc6_rdn = 6'b101010;
      5'd22:   enc6_rdn = 6'b011010;  5'd23: enc6_rdn = 6'b111010;
      5'd24:   enc6_rdn = 6'b110011;  5'd25: enc6_rdn = 6'b100110;
      5'd26:   enc6_rdn = 6'b010110;  5'd27: enc6_rdn = 6'b110110;
      5'd28:   enc6_rdn = 6'b001110;  5'd29: enc6_rdn = 6'b101110;
      5'd30:   enc6_rdn = 6'b011110;
      default: enc6_rdn = 6'b101011;
    endcase
  endfunction

  // 3b/4b data table, RD- column (fghj), primary D.x.P7 for HGF = 7.
  function automatic logic [3:0] enc4_rdn(input logic [2:0] y);
    case (y)
      3'd0:    enc4_rdn = 4'b1011;  3'd1: enc4_rdn = 4'b1001;
      3'd2:    enc4_rdn = 4'b0101;  3'd3: enc4_rdn = 4'b1100;
      3'd4:    enc4_rdn = 4'b1101;  3'd5: enc4_rdn = 4'b1010;
      3'd6:    enc4_rdn = 4'b0110;
      default: enc4_rdn = 4'b1110;
    endcase
  endfunction

  // 3b/4b control table for RD+ after the 6b sub-block. For control codes
  // every entry (neutral ones included) is inverted when RD is negative.
  function automatic logic [3:0] kenc4_rdp(input logic [2:0] y);
    case (y)
      3'd0:    kenc4_rdp = 4'b0100;  3'd1: kenc4_rdp = 4'b1001;
      3'd2:    kenc4_rdp = 4'b0101;  3'd3: kenc4_rdp = 4'b0011;
      3'd4:    kenc4_rdp = 4'b0010;  3'd5: kenc4_rdp = 4'b1010;
      3'd6:    kenc4_rdp = 4'b0110;
      default: kenc4_rdp = 4'b1000;
    endcase
  endfunction

  function automatic logic [2:0] ones6(input logic [5:0] v);
    ones6 = 3'd0;
    for (int i = 0; i < 6; i++) ones6 = ones6 + {2'b00, v[i]};
  endfunction

  function automatic logic [2:0] ones4(input logic [3:0] v);
    ones4 = 3'd0;
    for (int i = 0; i < 4; i++) ones4 = ones4 + {2'b00, v[i]};
  endfunction

  logic       hold_full_q, hold_full_d;
  logic [7:0] hold_data_q, hold_data_d;
  logic [9:0] shift_q,     shift_d;
  logic [3:0] cnt_q,       cnt_d;
  logic       active_q,    active_d;
  logic       rd_q,        rd_d;
  logic       ready_q,     ready_d;
`ifdef SERIALIZER_KCHAR_EN
  logic       hold_k_q,    hold_k_d;
  logic       k_err_q,     k_err_d;
`endif

  logic       accept, load;
  logic [4:0] x;
  logic [2:0] y;
  logic       k_req, k_ok, use_k;
  logic [5:0] code6;
  logic [3:0] code4;
  logic       bal6, rd6, rd10;

  always_comb begin
    accept = i_Valid && ready_q;
    // Load on an idle shifter or on the bit-j cycle, so symbols abut.
    load   = hold_full_q && (!active_q || (cnt_q == 4'd9));

    x = hold_data_q[4:0];
    y = hold_data_q[7:5];
`ifdef SERIALIZER_KCHAR_EN
    k_req = hold_k_q;
`else
    k_req = 1'b0;
`endif
    k_ok  = (x == 5'd28) ||
            ((y == 3'd7) && ((x == 5'd23) || (x == 5'd27) || (x == 5'd29) || (x == 5'd30)));
    use_k = k_req && k_ok;

    // 6b sub-block: RD+ inverts unbalanced codes and 111000. The 111000/000111
    // pair leaves RD where it was (ends low / ends high respectively).
    code6 = enc6_rdn(x);
    if (use_k && (x == 5'd28)) code6 = 6'b001111;
    bal6 = (ones6(code6) == 3'd3);
    if (rd_q && (!bal6 || (code6 == 6'b111000))) code6 = ~code6;
    rd6 = bal6 ? rd_q : ~rd_q;

    // 4b sub-block chosen from the RD left by the 6b sub-block.
    if (use_k) begin
      code4 = kenc4_rdp(y);
      if (!rd6) code4 = ~code4;
    end else begin
      code4 = enc4_rdn(y);
      // Alternate A7 avoids a run of five equal bits across the boundary.
      if ((y == 3'd7) && (rd6 ? ((x == 5'd11) || (x == 5'd13) || (x == 5'd14))
                              : ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))))
        code4 = 4'b0111;
      if (rd6 && ((ones4(code4) != 3'd2) || (code4 == 4'b1100))) code4 = ~code4;
    end
    rd10 = (ones4(code4) == 3'd2) ? rd6 : ~rd6;

    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    active_d    = active_q;
    rd_d        = rd_q;
`ifdef SERIALIZER_KCHAR_EN
    hold_k_d    = hold_k_q;
    k_err_d     = 1'b0;
`endif

    if (load) begin
      shift_d     = {code6, code4};
      cnt_d       = 4'd0;
      active_d    = 1'b1;
      rd_d        = rd10;
      hold_full_d = 1'b0;
`ifdef SERIALIZER_KCHAR_EN
      k_err_d     = k_req && !k_ok;
`endif
    end else if (active_q) begin
      if (cnt_q == 4'd9) begin
        // Zeroing the shifter keeps the serial line low while idle.
        shift_d  = 10'd0;
        cnt_d    = 4'd0;
        active_d = 1'b0;
      end else begin
        shift_d = {shift_q[8:0], 1'b0};
        cnt_d   = cnt_q + 4'd1;
      end
    end

    if (accept) begin
      hold_full_d = 1'b1;
      hold_data_d = i_Data;
`ifdef SERIALIZER_KCHAR_EN
      hold_k_d    = i_K;
`endif
    end

    ready_d = ~hold_full_d;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      hold_full_q <= 1'b0;
      hold_data_q <= 8'd0;
      shift_q     <= 10'd0;
      cnt_q       <= 4'd0;
      active_q    <= 1'b0;
      rd_q        <= 1'b0;
      ready_q     <= 1'b0;
`ifdef SERIALIZER_KCHAR_EN
      hold_k_q    <= 1'b0;
      k_err_q     <= 1'b0;
`endif
    end else begin
      hold_full_q <= hold_full_d;
      hold_data_q <= hold_data_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      active_q    <= active_d;
      rd_q        <= rd_d;
      ready_q     <= ready_d;
`ifdef SERIALIZER_KCHAR_EN
      hold_k_q    <= hold_k_d;
      k_err_q     <= k_err_d;
`endif
    end
  end

  assign o_Ready     = ready_q;
  assign o_Data_Out  = shift_q[9];
  assign o_Tx_Active = active_q;
  assign o_Rd        = rd_q;
`ifdef SERIALIZER_KCHAR_EN
  assign o_K_Err     = k_err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serializer_8b10b.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serializer_8b10b
//  Purpose  : Self-checking bench for serializer_8b10b. A table-driven 8b/10b
//             reference (both RD columns listed, disparity derived from the
//             code bits) predicts every symbol; a line monitor compares each
//             serial bit, o_Rd at symbol start and idle behaviour.
//  Options  : SERIALIZER_KCHAR_EN - also exercises control characters
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serializer_8b10b;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic       valid;
  logic       ready, dout, tx_active, rd;
`ifdef SERIALIZER_KCHAR_EN
  logic       k_in, k_err;
`endif

  always #5 clk = ~clk;

  serializer_8b10b dut (
    .i_Clk      (clk),
    .i_Rst      (rst),
    .i_Data     (data),
    .i_Valid    (valid),
`ifdef SERIALIZER_KCHAR_EN
    .i_K        (k_in),
    .o_K_Err    (k_err),
`endif
    .o_Ready    (ready),
    .o_Data_Out (dout),
    .o_Tx_Active(tx_active),
    .o_Rd       (rd)
  );

  typedef struct packed { logic [9:0] code; logic rd; logic kerr; } sym_t;

  // Reference tables: index = EDCBA / HGF, columns by current RD.
  logic [5:0] t6n [0:31] = '{6'b100111,6'b011101,6'b101101,6'b110001,6'b110101,6'b101001,6'b011001,6'b111000,
                             6'b111001,6'b100101,6'b010101,6'b110100,6'b001101,6'b101100,6'b011100,6'b010111,
                             6'b011011,6'b100011,6'b010011,6'b110010,6'b001011,6'b101010,6'b011010,6'b111010,
                             6'b110011,6'b100110,6'b010110,6'b110110,6'b001110,6'b101110,6'b011110,6'b101011};
  logic [5:0] t6p [0:31] = '{6'b011000,6'b100010,6'b010010,6'b110001,6'b001010,6'b101001,6'b011001,6'b000111,
                             6'b000110,6'b100101,6'b010101,6'b110100,6'b001101,6'b101100,6'b011100,6'b101000,
                             6'b100100,6'b100011,6'b010011,6'b110010,6'b001011,6'b101010,6'b011010,6'b000101,
                             6'b001100,6'b100110,6'b010110,6'b001001,6'b001110,6'b010001,6'b100001,6'b010100};
  logic [3:0] t4n [0:7] = '{4'b1011,4'b1001,4'b0101,4'b1100,4'b1101,4'b1010,4'b0110,4'b1110};
  logic [3:0] t4p [0:7] = '{4'b0100,4'b1001,4'b0101,4'b0011,4'b0010,4'b1010,4'b0110,4'b0001};
  logic [3:0] k4n [0:7] = '{4'b1011,4'b0110,4'b1010,4'b1100,4'b1101,4'b0101,4'b1001,4'b0111};
  logic [3:0] k4p [0:7] = '{4'b0100,4'b1001,4'b0101,4'b0011,4'b0010,4'b1010,4'b0110,4'b1000};
`ifdef SERIALIZER_KCHAR_EN
  logic [7:0] kvalid [0:11] = '{8'h1C,8'h3C,8'h5C,8'h7C,8'h9C,8'hBC,8'hDC,8'hFC,8'hF7,8'hFB,8'hFD,8'hFE};
`endif

  int   n_chk = 0;
  int   n_err = 0;
  sym_t q[$];
  logic model_rd = 1'b0;

  logic       mon_en = 1'b0;
  int         pos = 0;
  int         sym_cnt = 0;
  logic [9:0] cap = 10'd0;
  logic [9:0] last_sym = 10'd0;
  int         act_cnt = 0, act_rise = 0, rdy_rise = 0, kerr_cnt = 0;
  logic       prev_active = 1'b0, prev_ready = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Sub-block disparity rule: more ones -> RD+, more zeros -> RD-; among
  // balanced blocks 000111/0011 end RD+, 111000/1100 end RD-, others keep RD.
  function automatic logic blk_rd(input logic [5:0] v, input int width, input logic rd_in);
    int ones = $countones(v);
    if (2 * ones > width) return 1'b1;
    if (2 * ones < width) return 1'b0;
    if (width == 6 && v == 6'b000111) return 1'b1;
    if (width == 6 && v == 6'b111000) return 1'b0;
    if (width == 4 && v[3:0] == 4'b0011) return 1'b1;
    if (width == 4 && v[3:0] == 4'b1100) return 1'b0;
    return rd_in;
  endfunction

  function automatic sym_t model_enc(input logic [7:0] b, input logic k, input logic rd_in);
    sym_t s;
    int   xv = int'(b[4:0]);
    int   yv = int'(b[7:5]);
    logic kv, r6;
    logic [5:0] s6;
    logic [3:0] s4;
    kv = k && (xv == 28 || (yv == 7 && (xv == 23 || xv == 27 || xv == 29 || xv == 30)));
    s6 = rd_in ? t6p[xv] : t6n[xv];
    if (kv && xv == 28) s6 = rd_in ? 6'b110000 : 6'b001111;
    r6 = blk_rd(s6, 6, rd_in);
    if (kv)
      s4 = r6 ? k4p[yv] : k4n[yv];
    else if (yv == 7 && ((!r6 && (xv == 17 || xv == 18 || xv == 20)) ||
                         ( r6 && (xv == 11 || xv == 13 || xv == 14))))
      s4 = r6 ? 4'b1000 : 4'b0111;
    else
      s4 = r6 ? t4p[yv] : t4n[yv];
    s.code = {s6, s4};
    s.rd   = blk_rd({2'b00, s4}, 4, r6);
    s.kerr = k && !kv;
    return s;
  endfunction

  // Line monitor: every active bit must match the predicted symbol stream.
  always @(negedge clk) begin
    if (mon_en) begin
      if (tx_active) begin
        act_cnt++;
        if (!prev_active) act_rise++;
        if (ready && !prev_ready) rdy_rise++;
        if (q.size() == 0) begin
          check_eq("spurious_bit", 32'd1, 32'd0);
        end else begin
          check_eq("serial_bit", {31'd0, dout}, {31'd0, q[0].code[9 - pos]});
          if (pos == 0) check_eq("rd_at_load", {31'd0, rd}, {31'd0, q[0].rd});
`ifdef SERIALIZER_KCHAR_EN
          check_eq("k_err", {31'd0, k_err}, {31'd0, (pos == 0) ? q[0].kerr : 1'b0});
          if (k_err) kerr_cnt++;
`endif
          cap = {cap[8:0], dout};
          pos++;
          if (pos == 10) begin
            last_sym = cap;
            pos = 0;
            sym_cnt++;
            void'(q.pop_front());
          end
        end
      end else begin
        check_eq("idle_low", {31'd0, dout}, 32'd0);
        check_eq("no_gap_mid_symbol", pos, 0);
        if (pos != 0) begin
          pos = 0;
          if (q.size() != 0) void'(q.pop_front());
        end
`ifdef SERIALIZER_KCHAR_EN
        check_eq("k_err_idle", {31'd0, k_err}, 32'd0);
`endif
      end
      prev_active = tx_active;
      prev_ready  = ready;
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic k, input logic hold);
    int   n = 0;
    sym_t s;
    @(negedge clk);
    while (!ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      check_eq("ready_timeout", 32'd0, 32'd1);
      return;
    end
    data  = d;
    valid = 1'b1;
`ifdef SERIALIZER_KCHAR_EN
    k_in  = k;
`endif
    @(posedge clk);
    s = model_enc(d, k, model_rd);
    q.push_back(s);
    model_rd = s.rd;
    #1;
    if (!hold) begin
      valid = 1'b0;
      data  = 8'($urandom);
`ifdef SERIALIZER_KCHAR_EN
      k_in  = 1'($urandom);
`endif
    end
  endtask

  task automatic wait_sym(input int target);
    int n = 0;
    while (sym_cnt < target && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_eq("symbol_done", sym_cnt, target);
  endtask

  task automatic send_and_check(input logic [7:0] d, input logic k, input string tag,
                                input logic [9:0] exp_sym, input logic exp_rd);
    send_byte(d, k, 1'b0);
    wait_sym(sym_cnt + 1);
    check_eq(tag, {22'd0, last_sym}, {22'd0, exp_sym});
    check_eq({tag, "_rd"}, {31'd0, rd}, {31'd0, exp_rd});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; valid = 1'b0; data = 8'd0;
`ifdef SERIALIZER_KCHAR_EN
    k_in = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready",  {31'd0, ready},     32'd0);
    check_eq("rst_active", {31'd0, tx_active}, 32'd0);
    check_eq("rst_dout",   {31'd0, dout},      32'd0);
    check_eq("rst_rd",     {31'd0, rd},        32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_eq("ready_low_first_cycle", {31'd0, ready}, 32'd0);
    @(negedge clk);
    check_eq("ready_after_rst", {31'd0, ready}, 32'd1);
    prev_ready = 1'b1;
    #1 mon_en = 1'b1;

    // First byte into an idle block: first bit one cycle after accept.
    send_byte(8'h00, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("lat_not_yet", {31'd0, tx_active}, 32'd0);
    @(negedge clk);
    check_eq("lat_first_bit", {31'd0, tx_active}, 32'd1);
    wait_sym(1);
    check_eq("d0_0_first", {22'd0, last_sym}, {22'd0, 10'b1001110100});
    check_eq("d0_0_first_rd", {31'd0, rd}, 32'd0);

    send_and_check(8'h00, 1'b0, "d0_0_again", 10'b1001110100, 1'b0);
    send_and_check(8'h03, 1'b0, "d3_0_rdn",   10'b1100011011, 1'b1);
    send_and_check(8'hB5, 1'b0, "d21_5_rdp",  10'b1010101010, 1'b1);
    send_and_check(8'h03, 1'b0, "d3_0_rdp",   10'b1100010100, 1'b0);
    send_and_check(8'hF1, 1'b0, "d17_7_alt",  10'b1000110111, 1'b1);

    // Back-to-back stream with valid held high.
    @(negedge clk); #1;
    act_cnt = 0; act_rise = 0; rdy_rise = 0;
    n = sym_cnt;
    send_byte(8'h00, 1'b0, 1'b1);
    send_byte(8'hB5, 1'b0, 1'b1);
    send_byte(8'h03, 1'b0, 1'b0);
    wait_sym(n + 3);
    @(negedge clk); #1;
    check_eq("stream_active_cycles", act_cnt, 30);
    check_eq("stream_contiguous", act_rise, 1);
    check_eq("stream_ready_pulses", rdy_rise, 3);

`ifdef SERIALIZER_KCHAR_EN
    if (model_rd) begin
      send_byte(8'h03, 1'b0, 1'b0);
      wait_sym(sym_cnt + 1);
    end
    send_and_check(8'hBC, 1'b1, "k28_5_rdn", 10'b0011111010, 1'b1);
    send_and_check(8'hBC, 1'b1, "k28_5_rdp", 10'b1100000101, 1'b0);
    kerr_cnt = 0;
    send_and_check(8'h00, 1'b1, "bad_k_as_data", 10'b1001110100, 1'b0);
    check_eq("bad_k_err_pulses", kerr_cnt, 1);
`endif

    // Reset at bit 4 of a symbol with another byte waiting in holding.
    if (model_rd) begin
      send_byte(8'h03, 1'b0, 1'b0);
      wait_sym(sym_cnt + 1);
    end
    send_byte(8'h03, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    n = 0;
    while (pos != 5 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_eq("reached_bit4", pos, 5);
    check_eq("rd_before_reset", {31'd0, rd}, 32'd1);
    rst = 1'b1;
    mon_en = 1'b0;
    @(negedge clk);
    check_eq("midrst_dout",   {31'd0, dout},      32'd0);
    check_eq("midrst_active", {31'd0, tx_active}, 32'd0);
    check_eq("midrst_rd",     {31'd0, rd},        32'd0);
    check_eq("midrst_ready",  {31'd0, ready},     32'd0);
    @(posedge clk); #1 rst = 1'b0;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (tx_active || dout) n++;
    end
    check_eq("no_bits_after_reset", n, 0);
    check_eq("ready_after_midrst", {31'd0, ready}, 32'd1);
    q.delete();
    pos = 0; model_rd = 1'b0;
    prev_active = 1'b0; prev_ready = ready;
    #1 mon_en = 1'b1;

    // Randomized traffic, mixing gaps and held-valid streaming.
    for (int i = 0; i < 150; i++) begin
      logic [7:0] d;
      logic       kk;
      logic       h;
      d  = 8'($urandom);
      kk = 1'b0;
`ifdef SERIALIZER_KCHAR_EN
      if ($urandom_range(0, 3) == 0) begin
        kk = 1'b1;
        if ($urandom_range(0, 1) == 1) d = kvalid[$urandom_range(0, 11)];
      end
`endif
      h = (i != 149) && ($urandom_range(0, 1) == 1);
      send_byte(d, kk, h);
      if (!h) repeat ($urandom_range(0, 12)) @(posedge clk);
    end

    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_eq("queue_drained", q.size(), 0);
    @(negedge clk);
    check_eq("idle_at_end", {31'd0, tx_active}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
